pkt_rr_sched: RTL and testbench

- Per-output-port scheduler for the 5-port router crossbar.
- Shares one output port and its downstream buffer between the five input ports.
- Arbitration: round-robin, with multicast/absorb requests taking precedence over unicast.
- Holds a grant for the whole packet, head to tail, and gates every grant on downstream credit.
- Drives the crossbar mux select and the multicast contention flags consumed by the input-side multicast logic.

---
 rtl/pkt_rr_sched_pkg.sv | 13 +
 rtl/pkt_rr_sched_rr_pick.sv | 32 +++
 rtl/pkt_rr_sched.sv | 127 ++++++++++++
 tb/tb_pkt_rr_sched.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/pkt_rr_sched_pkg.sv
// Shared types and defaults for the per-output-port packet scheduler.
package pkt_rr_sched_pkg;

   typedef enum logic {
      SCHED_IDLE = 1'b0,
      SCHED_LOCK = 1'b1
   } sched_state_e;

   localparam int unsigned SCHED_NPORT   = 5;
   localparam int unsigned SCHED_CREDITS = 4;
   localparam int unsigned SCHED_CW      = 3;

endpackage

// File: rtl/pkt_rr_sched_rr_pick.sv
// Rotating priority encoder: scans ptr+1, ptr+2, ... modulo NPORT; first set bit wins.
module pkt_rr_sched_rr_pick
   import pkt_rr_sched_pkg::*;
#(
   parameter int unsigned NPORT = SCHED_NPORT,
   parameter int unsigned IW    = $clog2(NPORT)
) (
   input  logic [NPORT-1:0] req,
   input  logic [IW-1:0]    ptr,
   output logic [NPORT-1:0] gnt,
   output logic [IW-1:0]    winner,
   output logic             any
);

   int unsigned idx;

   always_comb begin
      gnt    = '0;
      winner = '0;
      any    = 1'b0;
      idx    = 0;
      for (int unsigned k = 1; k <= NPORT; k++) begin
         idx = (int'(unsigned'(ptr)) + k) % NPORT;
         if (!any && req[idx]) begin
            any      = 1'b1;
            gnt[idx] = 1'b1;
            winner   = IW'(idx);
         end
      end
   end

endmodule

// File: rtl/pkt_rr_sched.sv
// Output-port scheduler: round-robin with multicast precedence, packet lock and credit gating.
module pkt_rr_sched
   import pkt_rr_sched_pkg::*;
#(
   parameter int unsigned NPORT   = SCHED_NPORT,
   parameter int unsigned CREDITS = SCHED_CREDITS,
   parameter int unsigned CW      = SCHED_CW
) (
   input  logic             clk,
   input  logic             rst_,
   input  logic [NPORT-1:0] u_req,
   input  logic [NPORT-1:0] m_req,
   input  logic [NPORT-1:0] flit_tail,
   input  logic             credit_ret,
   output logic [NPORT-1:0] grt,
   output logic [NPORT-1:0] sel,
   output logic [NPORT-1:0] multab_ct,
   output logic             locked,
   output logic [CW-1:0]    credit_cnt,
   output logic             cred_err
);

   localparam int unsigned IW = $clog2(NPORT);

   sched_state_e   state_q, state_d;
   logic [IW-1:0]  owner_q, owner_d;
   logic [IW-1:0]  ptr_q, ptr_d;
   logic [CW-1:0]  credit_q, credit_d;
   logic           cred_err_q, cred_err_d;

   logic [NPORT-1:0] req_any;
   logic [NPORT-1:0] pick_req;
   logic [NPORT-1:0] pick_gnt;
   logic [IW-1:0]    pick_win;
   logic             pick_any;
   logic [IW-1:0]    win;
   logic             any_grt;

   assign req_any  = u_req | m_req;
   // Multicast/absorb requests fully mask unicast while any is pending.
   assign pick_req = (|m_req) ? m_req : u_req;

   pkt_rr_sched_rr_pick #(
      .NPORT (NPORT),
      .IW    (IW)
   ) u_pick (
      .req    (pick_req),
      .ptr    (ptr_q),
      .gnt    (pick_gnt),
      .winner (pick_win),
      .any    (pick_any)
   );

   always_comb begin
      grt = '0;
      win = owner_q;
      if (state_q == SCHED_IDLE) begin
         win = pick_win;
         if (credit_q != '0 && pick_any) begin
            grt = pick_gnt;
         end
      end else if (credit_q != '0) begin
         grt[owner_q] = req_any[owner_q];
      end
   end

   assign any_grt = |grt;

   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      ptr_d      = ptr_q;
      credit_d   = credit_q;
      cred_err_d = cred_err_q;

      case (state_q)
         SCHED_IDLE: begin
            if (any_grt) begin
               ptr_d = win;
               if (!flit_tail[win]) begin
                  state_d = SCHED_LOCK;
                  owner_d = win;
               end
            end
         end
         SCHED_LOCK: begin
            if (any_grt && flit_tail[owner_q]) begin
               state_d = SCHED_IDLE;
            end
         end
         default: state_d = SCHED_IDLE;
      endcase

      if (any_grt && !credit_ret) begin
         credit_d = credit_q - 1'b1;
      end else if (credit_ret && !any_grt) begin
         if (credit_q == CW'(CREDITS)) begin
            cred_err_d = 1'b1;
         end else begin
            credit_d = credit_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst_) begin
         state_q    <= SCHED_IDLE;
         owner_q    <= '0;
         ptr_q      <= IW'(NPORT - 1);
         credit_q   <= CW'(CREDITS);
         cred_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         ptr_q      <= ptr_d;
         credit_q   <= credit_d;
         cred_err_q <= cred_err_d;
      end
   end

   assign sel        = grt;
   assign multab_ct  = m_req & ~grt;
   assign locked     = (state_q == SCHED_LOCK);
   assign credit_cnt = credit_q;
   assign cred_err   = cred_err_q;

endmodule

// File: tb/tb_pkt_rr_sched.sv
// Directed bench for pkt_rr_sched with hand-computed expectations.
module tb_pkt_rr_sched;

   logic       clk;
   logic       rst_;
   logic [4:0] u_req;
   logic [4:0] m_req;
   logic [4:0] flit_tail;
   logic       credit_ret;
   logic [4:0] grt;
   logic [4:0] sel;
   logic [4:0] multab_ct;
   logic       locked;
   logic [2:0] credit_cnt;
   logic       cred_err;

   int unsigned errors = 0;
   int unsigned checks = 0;

   pkt_rr_sched #(
      .NPORT   (5),
      .CREDITS (4),
      .CW      (3)
   ) dut (
      .clk        (clk),
      .rst_       (rst_),
      .u_req      (u_req),
      .m_req      (m_req),
      .flit_tail  (flit_tail),
      .credit_ret (credit_ret),
      .grt        (grt),
      .sel        (sel),
      .multab_ct  (multab_ct),
      .locked     (locked),
      .credit_cnt (credit_cnt),
      .cred_err   (cred_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_ = 1'b1; u_req = '0; m_req = '0; flit_tail = '0; credit_ret = 1'b0;
      tick(); tick();
      rst_ = 1'b0; #1;
      chk("rst_locked", 32'(locked), 0);
      chk("rst_credit", 32'(credit_cnt), 4);
      chk("rst_err", 32'(cred_err), 0);
      chk("rst_grt", 32'(grt), 0);

      // round-robin unicast, single-flit packets
      u_req = 5'b10101; flit_tail = 5'b11111; #1;
      chk("rr_g0", 32'(grt), 32'b00001);
      chk("rr_sel0", 32'(sel), 32'b00001);
      tick();
      chk("rr_cnt3", 32'(credit_cnt), 3);
      chk("rr_g2", 32'(grt), 32'b00100);
      tick();
      chk("rr_cnt2", 32'(credit_cnt), 2);
      chk("rr_g4", 32'(grt), 32'b10000);
      tick();
      chk("rr_cnt1", 32'(credit_cnt), 1);
      credit_ret = 1'b1; #1;
      chk("rr_g0b", 32'(grt), 32'b00001);
      tick();
      chk("rr_cnt_hold", 32'(credit_cnt), 1);
      u_req = '0; tick(); tick(); tick();
      chk("rr_cnt_refill", 32'(credit_cnt), 4);
      chk("rr_err_clean", 32'(cred_err), 0);
      credit_ret = 1'b0;

      // multicast precedence; ptr=0 here
      u_req = 5'b00011; m_req = 5'b01000; #1;
      chk("mc_grt", 32'(grt), 32'b01000);
      chk("mc_ct", 32'(multab_ct), 0);
      tick();
      m_req = '0; #1;
      chk("mc_after_u0", 32'(grt), 32'b00001);
      tick();
      chk("mc_cnt2", 32'(credit_cnt), 2);
      u_req = '0; m_req = 5'b00100; #1;
      chk("mc_solo", 32'(grt), 32'b00100);
      m_req = 5'b10100; #1;
      chk("mc_contend_ct", 32'(multab_ct), 32'b10000);
      m_req = '0; credit_ret = 1'b1; #1;
      tick(); tick();
      chk("mc_refill", 32'(credit_cnt), 4);

      // 3-flit packet from port 1 with a bubble; ptr=0
      u_req = 5'b00110; flit_tail = 5'b00000; credit_ret = 1'b1; #1;
      chk("pk_f1", 32'(grt), 32'b00010);
      chk("pk_f1_unlocked", 32'(locked), 0);
      tick();
      chk("pk_f2", 32'(grt), 32'b00010);
      chk("pk_f2_locked", 32'(locked), 1);
      tick();
      u_req = 5'b00100; credit_ret = 1'b0; #1;
      chk("pk_bubble", 32'(grt), 0);
      tick();
      chk("pk_bubble_locked", 32'(locked), 1);
      u_req = 5'b00110; flit_tail = 5'b00010; credit_ret = 1'b1; #1;
      chk("pk_f3", 32'(grt), 32'b00010);
      tick();
      chk("pk_release", 32'(locked), 0);
      u_req = 5'b00100; flit_tail = 5'b00100; #1;
      chk("pk_next_p2", 32'(grt), 32'b00100);
      tick();
      chk("pk_cnt", 32'(credit_cnt), 4);
      u_req = '0; credit_ret = 1'b0; flit_tail = 5'b11111;

      // credit exhaustion; ptr=2
      u_req = 5'b01000; #1;
      for (int i = 0; i < 4; i++) begin
         chk("cx_grant", 32'(grt), 32'b01000);
         tick();
      end
      chk("cx_zero_grt", 32'(grt), 0);
      chk("cx_zero_cnt", 32'(credit_cnt), 0);
      credit_ret = 1'b1; #1;
      chk("cx_ret_grt", 32'(grt), 0);
      tick();
      credit_ret = 1'b0; #1;
      chk("cx_one_more", 32'(grt), 32'b01000);
      tick();
      chk("cx_again_zero", 32'(grt), 0);
      chk("cx_again_cnt", 32'(credit_cnt), 0);

      // simultaneous grant+return, then overflow
      u_req = '0; credit_ret = 1'b1;
      tick(); tick(); tick(); tick();
      chk("ov_refill", 32'(credit_cnt), 4);
      u_req = 5'b01000; #1;
      chk("ov_both_grt", 32'(grt), 32'b01000);
      tick();
      chk("ov_both_cnt", 32'(credit_cnt), 4);
      chk("ov_both_err", 32'(cred_err), 0);
      u_req = '0; #1;
      tick();
      chk("ov_cnt_hold", 32'(credit_cnt), 4);
      chk("ov_err_set", 32'(cred_err), 1);
      credit_ret = 1'b0;
      tick(); tick();
      chk("ov_err_sticky", 32'(cred_err), 1);

      // reset mid-packet; ptr=3
      u_req = 5'b00100; flit_tail = 5'b00000; #1;
      chk("mr_grant_p2", 32'(grt), 32'b00100);
      tick();
      chk("mr_locked", 32'(locked), 1);
      chk("mr_cnt3", 32'(credit_cnt), 3);
      u_req = 5'b00101; rst_ = 1'b1;
      tick();
      rst_ = 1'b0; #1;
      chk("mr_unlocked", 32'(locked), 0);
      chk("mr_cnt4", 32'(credit_cnt), 4);
      chk("mr_err_clr", 32'(cred_err), 0);
      chk("mr_grant_p0", 32'(grt), 32'b00001);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
